// File: rtl/power_est_pkg.sv
// power_est_pkg: shared constants, default widths and divider FSM states for the power activity estimator
package power_est_pkg;
  localparam int MW_PER_PJ_MHZ_DIV = 1000;
  localparam int NUM_EV_D = 4;
  localparam int EV_W_D = 8;
  localparam int EPJ_W_D = 16;
  localparam int WIN_LOG2_D = 10;
  localparam int ACC_W_D = 48;
  localparam int PWR_W_D = 16;
  localparam int FREQ_W = 16;
  typedef enum logic [1:0] {ACCUM, DIV, DONE} state_t;
endpackage

// File: rtl/power_activity_estimator_if.sv
// power_activity_estimator_if: activity/config inputs and power outputs; slave = estimator, master = driver of activity
interface power_activity_estimator_if #(
  parameter int NUM_EV = power_est_pkg::NUM_EV_D,
  parameter int EV_W = power_est_pkg::EV_W_D,
  parameter int EPJ_W = power_est_pkg::EPJ_W_D,
  parameter int PWR_W = power_est_pkg::PWR_W_D
) ();
  logic enable;
  logic [NUM_EV*EV_W-1:0] ev_count;
  logic [NUM_EV*EPJ_W-1:0] ev_energy_pj;
  logic [15:0] current_freq_mhz;
  logic [15:0] leak_nominal_mw;
  logic [PWR_W-1:0] dynamic_power_mw;
  logic [PWR_W-1:0] leakage_power_mw;
  logic power_valid;
  logic busy;
  modport slave (
    input enable, ev_count, ev_energy_pj, current_freq_mhz, leak_nominal_mw,
    output dynamic_power_mw, leakage_power_mw, power_valid, busy
  );
  modport master (
    output enable, ev_count, ev_energy_pj, current_freq_mhz, leak_nominal_mw,
    input dynamic_power_mw, leakage_power_mw, power_valid, busy
  );
endinterface

// File: rtl/power_est_div.sv
// power_est_div: serial restoring divider, one quotient bit per cycle; ports clk, reset (sync active-low), i_start/i_num/i_den in, o_last (final step happens at this edge), o_quot out
module power_est_div #(
  parameter int NUM_W = 64,
  parameter int DEN_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_last,
  output logic [NUM_W-1:0] o_quot
);
  localparam int CNT_W = $clog2(NUM_W + 1);
  logic [DEN_W-1:0] r_rem, r_den;
  logic [NUM_W-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic [DEN_W:0] w_sh, w_diff;
  assign w_sh = {r_rem, r_quo[NUM_W-1]};
  assign w_diff = w_sh - {1'b0, r_den};
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem <= '0;
      r_den <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_den <= i_den;
      r_quo <= i_num;
      r_cnt <= CNT_W'(NUM_W);
    end else if (r_cnt != '0) begin
      r_rem <= w_diff[DEN_W] ? w_sh[DEN_W-1:0] : w_diff[DEN_W-1:0];
      r_quo <= {r_quo[NUM_W-2:0], ~w_diff[DEN_W]};
      r_cnt <= r_cnt - 1'b1;
    end
  end
  assign o_last = r_cnt == CNT_W'(1);
  assign o_quot = r_quo;
endmodule

// File: rtl/power_activity_estimator.sv
// power_activity_estimator: windowed dynamic power (mW) from per-cycle event counts plus aligned leakage; ports clk, reset (sync active-low), bus (slave); optional POWER_EST_EMA_EN smooths dynamic power
module power_activity_estimator
  import power_est_pkg::*;
#(
  parameter int NUM_EV = NUM_EV_D,
  parameter int EV_W = EV_W_D,
  parameter int EPJ_W = EPJ_W_D,
  parameter int WIN_LOG2 = WIN_LOG2_D,
  parameter int ACC_W = ACC_W_D,
  parameter int PWR_W = PWR_W_D
) (
  input logic clk,
  input logic reset,
  power_activity_estimator_if.slave bus
);
  localparam int SUM_W = EV_W + EPJ_W + $clog2(NUM_EV);
  localparam int NUM_W = ACC_W + FREQ_W;
  localparam int DEN_W = $clog2(MW_PER_PJ_MHZ_DIV) + WIN_LOG2;
  localparam logic [DEN_W-1:0] DEN = DEN_W'(MW_PER_PJ_MHZ_DIV) << WIN_LOG2;
  state_t r_state, w_next;
  logic [SUM_W-1:0] w_sum, r_sum;
  logic r_v, r_valid, w_close, w_start, w_div_last;
  logic [ACC_W-1:0] r_win, w_acc;
  logic [ACC_W:0] w_add;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [NUM_W-1:0] w_num, w_quot;
  logic [PWR_W-1:0] r_leak_cap, r_dyn, r_leak, w_new, w_dyn;
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_EV; i++)
      w_sum += SUM_W'(bus.ev_count[i*EV_W +: EV_W]) * SUM_W'(bus.ev_energy_pj[i*EPJ_W +: EPJ_W]);
  end
  assign w_add = {1'b0, r_win} + (ACC_W + 1)'(r_sum);
  assign w_acc = w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
  assign w_close = r_v && &r_cnt;
  assign w_start = w_close && r_state == ACCUM;
  assign w_num = NUM_W'(w_acc) * NUM_W'(bus.current_freq_mhz);
  assign w_new = |w_quot[NUM_W-1:PWR_W] ? '1 : w_quot[PWR_W-1:0];
  always_comb begin
    w_next = r_state;
    w_next = r_state == ACCUM ? (w_start ? DIV : ACCUM) :
             r_state == DIV ? (w_div_last ? DONE : DIV) : ACCUM;
  end
  power_est_div #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_div (
    .clk(clk),
    .reset(reset),
    .i_start(w_start),
    .i_num(w_num),
    .i_den(DEN),
    .o_last(w_div_last),
    .o_quot(w_quot)
  );
`ifdef POWER_EST_EMA_EN
  logic r_first;
  always_ff @(posedge clk) begin
    if (!reset) r_first <= 1'b1;
    else if (r_state == DONE) r_first <= 1'b0;
  end
  assign w_dyn = r_first ? w_new : r_dyn - (r_dyn >> 2) + (w_new >> 2);
`else
  assign w_dyn = w_new;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ACCUM;
      r_sum <= '0;
      r_v <= 1'b0;
      r_win <= '0;
      r_cnt <= '0;
      r_leak_cap <= '0;
      r_dyn <= '0;
      r_leak <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sum <= w_sum;
      r_v <= bus.enable;
      if (r_v) begin
        r_win <= w_close ? '0 : w_acc;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_start) r_leak_cap <= PWR_W'(bus.leak_nominal_mw);
      if (r_state == DONE) begin
        r_dyn <= w_dyn;
        r_leak <= r_leak_cap;
      end
      r_valid <= r_state == DONE;
    end
  end
  assign bus.dynamic_power_mw = r_dyn;
  assign bus.leakage_power_mw = r_leak;
  assign bus.power_valid = r_valid;
  assign bus.busy = r_state == DIV;
endmodule

// File: tb/tb_power_activity_estimator.sv
// tb_power_activity_estimator: directed windows checked against a per-window energy model every cycle plus literal pins
module tb_power_activity_estimator;
  localparam int NUM_EV = 4;
  localparam int EV_W = 8;
  localparam int EPJ_W = 16;
  localparam int WIN_LOG2 = 7;
  localparam int ACC_W = 48;
  localparam int PWR_W = 16;
  localparam int W = 1 << WIN_LOG2;
  localparam longint unsigned EMAX = (64'd1 << ACC_W) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  power_activity_estimator_if #(.NUM_EV(NUM_EV), .EV_W(EV_W), .EPJ_W(EPJ_W), .PWR_W(PWR_W)) bus ();
  power_activity_estimator #(
    .NUM_EV(NUM_EV), .EV_W(EV_W), .EPJ_W(EPJ_W), .WIN_LOG2(WIN_LOG2), .ACC_W(ACC_W), .PWR_W(PWR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int errors = 0;
  longint cyc = 0;
  bit m_live = 0, m_pv = 0, m_pen = 0, m_first = 1, exp_valid = 0, exp_busy = 0;
  longint unsigned m_e = 0, m_pe = 0, qv;
  int m_n = 0;
  longint m_due = -1, m_bf = -1;
  logic [15:0] exp_dyn = 0, exp_leak = 0, m_q = 0, m_leak = 0;
  always @(posedge clk) begin
    cyc++;
    exp_valid = 0;
    if (!reset) begin
      m_live = 1; m_e = 0; m_n = 0; m_pv = 0; m_due = -1; m_bf = -1;
      exp_dyn = 0; exp_leak = 0; m_first = 1;
    end else begin
      if (m_pv && m_pen) begin
        m_e = (m_e + m_pe > EMAX) ? EMAX : m_e + m_pe;
        m_n++;
        if (m_n == W) begin
          qv = m_e * longint'(bus.current_freq_mhz) / longint'(1000 * W);
          m_q = qv > 65535 ? 16'hFFFF : qv[15:0];
          m_leak = bus.leak_nominal_mw;
          m_e = 0; m_n = 0; m_bf = cyc; m_due = cyc + 65;
        end
      end
      m_pe = 0;
      for (int i = 0; i < NUM_EV; i++)
        m_pe += longint'(bus.ev_count[i*EV_W +: EV_W]) * longint'(bus.ev_energy_pj[i*EPJ_W +: EPJ_W]);
      m_pen = bus.enable;
      m_pv = 1;
      if (cyc == m_due) begin
        exp_valid = 1;
        exp_leak = m_leak;
`ifdef POWER_EST_EMA_EN
        exp_dyn = m_first ? m_q : exp_dyn - exp_dyn / 4 + m_q / 4;
`else
        exp_dyn = m_q;
`endif
        m_first = 0;
      end
    end
    exp_busy = m_bf >= 0 && cyc >= m_bf && cyc <= m_bf + 63;
  end
  always @(negedge clk) begin
    if (m_live) begin
      vectors++;
      if (bus.power_valid !== exp_valid || bus.busy !== exp_busy ||
          bus.dynamic_power_mw !== exp_dyn || bus.leakage_power_mw !== exp_leak) begin
        errors++;
        $display("FAIL cycle %0d valid/busy/dyn/leak got %b/%b/%0d/%0d want %b/%b/%0d/%0d", cyc,
                 bus.power_valid, bus.busy, bus.dynamic_power_mw, bus.leakage_power_mw,
                 exp_valid, exp_busy, exp_dyn, exp_leak);
      end
    end
  end
  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  task automatic run_window(input string name, input logic [31:0] cnt, input logic [63:0] epj,
                            input logic [15:0] freq, input bit tog, input bit wait_v, input longint want);
    longint last = 0, vcyc = 0;
    bit got = 0;
    @(negedge clk);
    bus.ev_count = cnt;
    bus.ev_energy_pj = epj;
    bus.current_freq_mhz = freq;
    bus.leak_nominal_mw = 16'd13;
    for (int i = 0; i < (tog ? 2 * W : W); i++) begin
      if (i > 0) @(negedge clk);
      bus.enable = tog ? (i % 2 == 0) : 1'b1;
      if (bus.enable) last = cyc;
    end
    @(negedge clk);
    bus.enable = 1'b0;
    if (wait_v) begin
      for (int k = 0; k < 200 && !got; k++) begin
        if (bus.power_valid) begin
          got = 1;
          vcyc = cyc;
        end else @(negedge clk);
      end
      check({name, "_seen"}, longint'(got), 1);
      if (got) begin
        check({name, "_latency"}, vcyc - last, 67);
        check({name, "_dyn"}, longint'(bus.dynamic_power_mw), want);
        check({name, "_leak"}, longint'(bus.leakage_power_mw), 13);
      end
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int pulses;
    bus.enable = 0;
    bus.ev_count = '0;
    bus.ev_energy_pj = '0;
    bus.current_freq_mhz = 16'd250;
    bus.leak_nominal_mw = 16'd13;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset_dyn", longint'(bus.dynamic_power_mw), 0);
    check("reset_leak", longint'(bus.leakage_power_mw), 0);
    check("reset_valid", longint'(bus.power_valid), 0);
    check("reset_busy", longint'(bus.busy), 0);
`ifdef POWER_EST_EMA_EN
    run_window("ema1", 32'h1, 64'd100, 16'd250, 0, 1, 25);
    run_window("ema2", 32'h0, 64'd100, 16'd250, 0, 1, 19);
    run_window("ema3", 32'h0, 64'd100, 16'd250, 0, 1, 15);
`else
    run_window("single", 32'h1, 64'd100, 16'd250, 0, 1, 25);
    run_window("mixed", 32'h0000_0102, {16'd0, 16'd0, 16'd37, 16'd50}, 16'd250, 0, 1, 34);
    run_window("sat", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1000, 0, 1, 65535);
    run_window("toggle", 32'h1, 64'd100, 16'd250, 1, 1, 25);
    run_window("freq0", 32'h1, 64'd100, 16'd0, 0, 1, 0);
    run_window("prereset", 32'h1, 64'd100, 16'd250, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("midrst_busy", longint'(bus.busy), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("midrst_dyn", longint'(bus.dynamic_power_mw), 0);
    check("midrst_leak", longint'(bus.leakage_power_mw), 0);
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.power_valid) pulses++;
    end
    check("midrst_no_valid", longint'(pulses), 0);
    run_window("postrst", 32'h1, 64'd100, 16'd250, 0, 1, 25);
`endif
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/power_activity_estimator.md
Name: power_activity_estimator

Overview:
- Upstream feeder of the energy accumulator. Converts per-cycle NPU activity event counts (MAC ops, SRAM reads/writes, NoC flits) into windowed average dynamic power in mW.
- Also publishes the leakage power, aligned to the same update strobe.
- Outputs drive dynamic_power_mw / leakage_power_mw of the energy accumulator, which integrates them at current_freq_mhz.

Parameters:
- NUM_EV, 4, number of activity event classes
- EV_W, 8, per-cycle count width per event class
- EPJ_W, 16, per-event energy width (pJ)
- WIN_LOG2, 10, window length = 2^WIN_LOG2 enabled cycles; legal range 7..16
- ACC_W, 48, window energy accumulator width (pJ)
- PWR_W, 16, power output width (mW)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- enable  in  1  sample qualifier; when low, the cycle's counts are ignored
- ev_count  in  NUM_EV*EV_W  per-cycle event counts, class i at [i*EV_W +: EV_W]
- ev_energy_pj  in  NUM_EV*EPJ_W  per-event energy per class; quasi-static config
- current_freq_mhz  in  16  modeled core frequency
- leak_nominal_mw  in  16  leakage power to publish
- dynamic_power_mw  out  PWR_W  windowed dynamic power
- leakage_power_mw  out  PWR_W  leakage power, updated with dynamic_power_mw
- power_valid  out  1  one-cycle pulse when outputs update
- busy  out  1  divider active

Behaviour:
- Reset (reset==0 at posedge): all outputs 0; accumulator, window counter, stage-1 and divider state cleared; FSM to ACCUM.
- Stage 1 (registered):
  - ev_sum_q = sum over i of ev_count_i * ev_energy_i, full width (EV_W+EPJ_W+clog2(NUM_EV)).
  - v_q = enable.
- Accumulate:
  - When v_q, win_e += ev_sum_q, saturating at 2^ACC_W-1.
  - Window counter increments on v_q cycles only. enable low holds both.
- Window close: on the v_q cycle where the counter == 2^WIN_LOG2-1:
  - numerator = (win_e + ev_sum_q, saturated) * current_freq_mhz (ACC_W+16 bits).
  - leak_cap = leak_nominal_mw; frequency and leakage are sampled here only.
  - win_e <= 0 and the counter wraps to 0. The next window starts accumulating with no gap.
- Divider FSM: ACCUM -> DIV on window close; DIV -> DONE after ACC_W+16 iterations; DONE -> ACCUM after 1 cycle.
  - Restoring serial divide, one quotient bit per cycle.
  - divisor = 1000 << WIN_LOG2, so result = floor(E_pJ * f_MHz / (W*1000)).
  - busy = 1 in DIV.
- Output update in DONE:
  - dynamic_power_mw = min(quotient, 2^PWR_W-1).
  - leakage_power_mw = leak_cap.
  - power_valid = 1 for exactly one cycle.
- Latency: power_valid pulses exactly ACC_W+16+3 cycles (67 at defaults) after the cycle in which the window's final enabled sample is presented at the inputs.
- Divide completes before the next close, since 2^WIN_LOG2 >= 128 > 67.
- Outputs hold between updates.
- current_freq_mhz == 0 at close: result 0, valid still pulses.
- Mid-window frequency or leakage changes take effect only at the next close.
- Reset mid-DIV: result discarded, no power_valid. The first post-reset window starts clean.

Optional Feature:
- Macro: POWER_EST_EMA_EN.
- Defined:
  - dynamic_power_mw = old - (old>>2) + (new>>2), where new is the saturated quotient.
  - The first update after reset loads new directly.
- Undefined: raw per-window value, no smoothing state.

Decomposition:
- Package power_est_pkg:
  - MW_PER_PJ_MHZ_DIV = 1000.
  - Default widths.
  - FSM state enum {ACCUM, DIV, DONE}.
- Sub-module power_est_div: serial restoring divider with start/done handshake, parameterised on numerator/divisor widths.
- MAC tree and accumulator stay in the top module.

Test Plan (WIN_LOG2=7, W=128, freq=250 unless stated):
- ev0 count=1, energy=100 pJ every cycle, others 0 -> window E=12800 -> dynamic_power_mw=25, leakage_power_mw=13 (leak_nominal_mw=13), power_valid pulses 67 cycles after the 128th sample.
- ev0 count=2 @50 pJ plus ev1 count=1 @37 pJ -> 137 pJ/cycle, E=17536 -> dynamic_power_mw=34 (truncated from 34.25).
- Saturation: freq=1000, all counts 255, all energies 65535 -> dynamic_power_mw=0xFFFF.
- enable toggling every other cycle, test-1 stimulus -> close after 256 clocks, dynamic_power_mw=25; the counter must not advance on disabled cycles.
- reset asserted for 2 cycles while busy=1 -> outputs 0, no power_valid; the next full window yields 25.
- With POWER_EST_EMA_EN: window1 E=12800 -> 25; window2 all counts 0 -> 25-6+0 = 19; window3 counts 0 -> 19-4 = 15.
